reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement stage of the Tomasulo core, sitting between the dispatcher/CDB and the register file. It allocates one entry per dispatched instruction and collects results from the ALU and LSB broadcast buses. It retires the head entry in program order, driving the register file's commit port, and signals the LSB to perform stores. On a mispredicted branch it raises a rollback that flushes itself and the register file's rename tags.

## Interface
- ROB_SIZE, 16: entry count. ROB id = index + 1; id 0 (`ZERO_ROB`) means "no producer".
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low, all state and outputs hold.
- alloc_signal_from_dispatcher  in  1  allocate tail entry.
- rd_from_dispatcher  in  5  destination register.
- is_store_from_dispatcher, is_branch_from_dispatcher  in  1 each  entry kind.
- predicted_taken_from_dispatcher  in  1  predictor decision.
- rob_id_to_dispatcher  out  5  id the next allocation receives (tail + 1).
- full_to_dispatcher  out  1  count == ROB_SIZE.
- query_Q1, query_Q2  in  5 each  producer ids to probe.
- query_ready1/2  out  1 each  probed entry is busy and ready.
- query_value1/2  out  32 each  probed entry's value.
- alu_valid, alu_rob_id(5), alu_value(32), alu_taken(1), alu_target_pc(32)  in  ALU broadcast.
- lsb_valid, lsb_rob_id(5), lsb_value(32)  in  LSB broadcast.
- commit_flag  out  1  one-cycle pulse, feeds register file input_commit_flag.
- commit_rd(5), commit_rob_id(5), commit_value(32)  out  register-file commit data.
- store_commit_flag(1), store_commit_rob_id(5)  out  store release to LSB.
- rollback_flag(1), rollback_pc(32)  out  flush pulse plus redirect target.

## Operation
- Circular buffer with 4-bit head and tail pointers and a 5-bit count. Per entry: busy, ready, rd, value, is_store, is_branch, predicted_taken, actual_taken, target_pc.
- Alloc: writes the tail entry with busy=1 and ready=0. Tail advances modulo ROB_SIZE.
  - Stores arrive ready=1 (value irrelevant).
  - An alloc while full is ignored.
- Writeback: a valid CDB entry whose id matches a busy entry sets ready=1 and the value. The ALU bus also sets actual_taken and target_pc.
  - Both buses may write in the same cycle; their ids are distinct by construction.
  - Id 0 and ids of non-busy entries are ignored.
- Query: combinational lookup. Ready and value are the stored entry's, except that a same-cycle CDB match forwards the bus value with ready=1. Id 0 returns ready=0, value 0.
- Commit, at most one per cycle, when head is busy and ready:
  - commit_flag=1 with the head's rd, id and value. A store commits with rd=0 and also pulses store_commit_flag.
  - A branch with actual_taken != predicted_taken additionally pulses rollback_flag, with rollback_pc = target_pc.
  - Head advances and the entry is cleared.
- Rollback cycle: on the same clock edge, all entries are cleared and head=tail=count=0. Same-cycle allocs and writebacks are discarded.
- Alloc and commit in one cycle: count is unchanged. Pointer wrap 15→0 is seamless.
- rdy low: no state change; commit, store and rollback pulses are 0.

## Timing
- Reset: head=tail=count=0, all busy=0. Every registered output is 0, including commit_*, store_commit_*, rollback_flag and rollback_pc.
- rob_id_to_dispatcher resets to 1 and full_to_dispatcher resets to 0. Both derive combinationally from the registered pointer and count.
- Alloc at edge N → entry busy from cycle N+1, and full reflects it in cycle N+1.
- Writeback in cycle N → ready at edge N+1. If that entry is head, commit outputs are registered at edge N+2, giving a 2-cycle writeback-to-commit latency.
- Commit outputs are single-cycle registered pulses. Back-to-back commits are allowed every cycle.
- Rollback is visible in the same cycle as the offending commit. Dispatch resumes with id 1 in the following cycle.
- Reset asserted mid-operation discards all entries at the next edge. No pending pulse survives.

## Structure
- Shared constants come from constant.v: `ROB_ID_TYPE`, `REG_POS_TYPE`, `DATA_TYPE`, `ADDR_TYPE`, `ZERO_ROB`, `ZERO_REG`, `ZERO_WORD`, `ROB_SIZE`.
- A single module. A sub-module is not warranted; the query lookup is two combinational muxes.

## Test plan
- Reset, then alloc rd=5 and ALU writeback id 1 with value 0x2A → commit_flag, commit_rd=5, commit_rob_id=1, commit_value=0x2A two cycles after the writeback.
- Alloc ids 1–3, with writebacks in order 3,2,1 → commits retire ids 1,2,3 on consecutive cycles.
- 16 allocs → full=1 and a 17th alloc is ignored. One commit plus one alloc in the same cycle → full stays 1, and the new id wraps to 1.
- Branch with predicted_taken=0, ALU taken=1, target 0x100 → rollback_flag=1 and rollback_pc=0x100. Next cycle count=0 and rob_id_to_dispatcher=1.
- Store alloc → store_commit_flag with its id at head, and commit_rd=0.
- query_Q1=id 2 while the ALU broadcasts id 2 with value 7 → query_ready1=1 and query_value1=7 in the same cycle. rdy low during a ready head → no commit until rdy returns.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: ROB ids, register
// positions, data words and the per-entry payload layout.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;

  typedef logic [4:0]  rob_id_t;
  typedef logic [3:0]  rob_idx_t;
  typedef logic [4:0]  rob_count_t;
  typedef logic [4:0]  reg_pos_t;
  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  localparam rob_id_t    ZERO_ROB       = 5'd0;
  localparam reg_pos_t   ZERO_REG       = 5'd0;
  localparam data_t      ZERO_WORD      = 32'd0;
  localparam addr_t      ZERO_ADDR      = 32'd0;
  localparam rob_count_t ROB_FULL_COUNT = 5'd16;

  typedef struct packed {
    reg_pos_t rd;
    data_t    value;
    logic     is_store;
    logic     is_branch;
    logic     predicted_taken;
    logic     actual_taken;
    addr_t    target_pc;
  } rob_payload_t;

  typedef struct packed {
    logic  ready;
    data_t value;
  } query_result_t;

  // Ids are 1-based so that id 0 can mean "no producer".
  function automatic rob_id_t idx_to_id(input rob_idx_t idx);
    return rob_id_t'({1'b0, idx}) + 5'd1;
  endfunction

  function automatic rob_idx_t id_to_idx(input rob_id_t id);
    rob_id_t biased;
    biased = id - 5'd1;
    return biased[3:0];
  endfunction

  function automatic logic id_in_range(input rob_id_t id);
    return (id != ZERO_ROB) && (id <= ROB_FULL_COUNT);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement stage: allocates entries at dispatch, collects ALU/LSB
// results, retires the head to the register file and flushes on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,

  input  logic     alloc_signal_from_dispatcher,
  input  reg_pos_t rd_from_dispatcher,
  input  logic     is_store_from_dispatcher,
  input  logic     is_branch_from_dispatcher,
  input  logic     predicted_taken_from_dispatcher,
  output rob_id_t  rob_id_to_dispatcher,
  output logic     full_to_dispatcher,

  input  rob_id_t  query_Q1,
  input  rob_id_t  query_Q2,
  output logic     query_ready1,
  output logic     query_ready2,
  output data_t    query_value1,
  output data_t    query_value2,

  input  logic     alu_valid,
  input  rob_id_t  alu_rob_id,
  input  data_t    alu_value,
  input  logic     alu_taken,
  input  addr_t    alu_target_pc,

  input  logic     lsb_valid,
  input  rob_id_t  lsb_rob_id,
  input  data_t    lsb_value,

  output logic     commit_flag,
  output reg_pos_t commit_rd,
  output rob_id_t  commit_rob_id,
  output data_t    commit_value,

  output logic     store_commit_flag,
  output rob_id_t  store_commit_rob_id,

  output logic     rollback_flag,
  output addr_t    rollback_pc
);

  rob_idx_t                head_q, head_d;
  rob_idx_t                tail_q, tail_d;
  rob_count_t              count_q, count_d;
  logic     [ROB_SIZE-1:0] busy_q, busy_d;
  logic     [ROB_SIZE-1:0] ready_q, ready_d;
  rob_payload_t            payload_q [ROB_SIZE];

  logic     [ROB_SIZE-1:0] alu_hit, lsb_hit;
  logic                    full;
  logic                    commit_fire, alloc_fire, mispredict;
  rob_payload_t            head_entry;

  logic     commit_flag_d, store_commit_flag_d, rollback_flag_d;
  reg_pos_t commit_rd_d;
  rob_id_t  commit_rob_id_d, store_commit_rob_id_d;
  data_t    commit_value_d;
  addr_t    rollback_pc_d;

  assign full                 = (count_q == ROB_FULL_COUNT);
  assign full_to_dispatcher   = full;
  assign rob_id_to_dispatcher = idx_to_id(tail_q);

  assign head_entry  = payload_q[head_q];
  assign commit_fire = rdy && busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && head_entry.is_branch &&
                       (head_entry.actual_taken != head_entry.predicted_taken);
  // A full buffer still accepts an alloc in the cycle its head retires.
  assign alloc_fire  = rdy && alloc_signal_from_dispatcher && (!full || commit_fire);

  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      alu_hit[i] = rdy && alu_valid && busy_q[i] && (alu_rob_id == idx_to_id(rob_idx_t'(i)));
      lsb_hit[i] = rdy && lsb_valid && busy_q[i] && (lsb_rob_id == idx_to_id(rob_idx_t'(i)));
    end
  end

  function automatic query_result_t lookup(
    input rob_id_t q,
    input logic    busy,
    input logic    ready,
    input data_t   stored,
    input logic    alu_v,
    input rob_id_t alu_id,
    input data_t   alu_val,
    input logic    lsb_v,
    input rob_id_t lsb_id,
    input data_t   lsb_val
  );
    query_result_t r;
    r.ready = 1'b0;
    r.value = ZERO_WORD;
    if (id_in_range(q) && busy) begin
      if (alu_v && (alu_id == q)) begin
        r.ready = 1'b1;
        r.value = alu_val;
      end else if (lsb_v && (lsb_id == q)) begin
        r.ready = 1'b1;
        r.value = lsb_val;
      end else begin
        r.ready = ready;
        r.value = stored;
      end
    end
    return r;
  endfunction

  rob_idx_t      q1_idx, q2_idx;
  query_result_t q1_res, q2_res;

  assign q1_idx = id_to_idx(query_Q1);
  assign q2_idx = id_to_idx(query_Q2);
  assign q1_res = lookup(query_Q1, busy_q[q1_idx], ready_q[q1_idx], payload_q[q1_idx].value,
                         alu_valid, alu_rob_id, alu_value, lsb_valid, lsb_rob_id, lsb_value);
  assign q2_res = lookup(query_Q2, busy_q[q2_idx], ready_q[q2_idx], payload_q[q2_idx].value,
                         alu_valid, alu_rob_id, alu_value, lsb_valid, lsb_rob_id, lsb_value);

  assign query_ready1 = q1_res.ready;
  assign query_value1 = q1_res.value;
  assign query_ready2 = q2_res.ready;
  assign query_value2 = q2_res.value;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q | alu_hit | lsb_hit;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (commit_fire) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 4'd1;
    end

    if (alloc_fire) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = is_store_from_dispatcher;
      tail_d          = tail_q + 4'd1;
    end

    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    if (mispredict) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Retirement outputs are zero in every cycle that does not retire.
  always_comb begin
    commit_flag_d         = commit_fire;
    commit_rd_d           = ZERO_REG;
    commit_rob_id_d       = ZERO_ROB;
    commit_value_d        = ZERO_WORD;
    store_commit_flag_d   = 1'b0;
    store_commit_rob_id_d = ZERO_ROB;
    rollback_flag_d       = mispredict;
    rollback_pc_d         = ZERO_ADDR;

    if (commit_fire) begin
      commit_rd_d     = head_entry.is_store ? ZERO_REG : head_entry.rd;
      commit_rob_id_d = idx_to_id(head_q);
      commit_value_d  = head_entry.value;
      if (head_entry.is_store) begin
        store_commit_flag_d   = 1'b1;
        store_commit_rob_id_d = idx_to_id(head_q);
      end
      if (mispredict) begin
        rollback_pc_d = head_entry.target_pc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      busy_q              <= '0;
      ready_q             <= '0;
      commit_flag         <= 1'b0;
      commit_rd           <= ZERO_REG;
      commit_rob_id       <= ZERO_ROB;
      commit_value        <= ZERO_WORD;
      store_commit_flag   <= 1'b0;
      store_commit_rob_id <= ZERO_ROB;
      rollback_flag       <= 1'b0;
      rollback_pc         <= ZERO_ADDR;
    end else begin
      head_q              <= head_d;
      tail_q              <= tail_d;
      count_q             <= count_d;
      busy_q              <= busy_d;
      ready_q             <= ready_d;
      commit_flag         <= commit_flag_d;
      commit_rd           <= commit_rd_d;
      commit_rob_id       <= commit_rob_id_d;
      commit_value        <= commit_value_d;
      store_commit_flag   <= store_commit_flag_d;
      store_commit_rob_id <= store_commit_rob_id_d;
      rollback_flag       <= rollback_flag_d;
      rollback_pc         <= rollback_pc_d;
    end
  end

  // NOTE: the payload array is deliberately left without reset; busy/ready
  // qualify every read, so stale payload is never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (alu_hit[i]) begin
        payload_q[i].value        <= alu_value;
        payload_q[i].actual_taken <= alu_taken;
        payload_q[i].target_pc    <= alu_target_pc;
      end
      if (lsb_hit[i]) begin
        payload_q[i].value <= lsb_value;
      end
    end
    if (alloc_fire) begin
      payload_q[tail_q] <= '{rd:              rd_from_dispatcher,
                             value:           ZERO_WORD,
                             is_store:        is_store_from_dispatcher,
                             is_branch:       is_branch_from_dispatcher,
                             predicted_taken: predicted_taken_from_dispatcher,
                             actual_taken:    1'b0,
                             target_pc:       ZERO_ADDR};
    end
  end

endmodule
